peri_pwm_multi: RTL and testbench

- Parametrised multi-channel PWM peripheral on the Wishbone B4 bus.
- NCHAN channels share one prescaled period counter with a programmable top value.
- Duty writes are staged and applied only at period wrap, so outputs never glitch mid-period.
- Successor to the single-channel fixed-256-step PWM. Adds enable, prescaler, period, readback and a wrap status flag.

---
 rtl/peri_pwm_multi.sv | 209 ++++++++++++++++++++
 tb/tb_peri_pwm_multi.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peri_pwm_multi.sv
// peri_pwm_multi: NCHAN-channel PWM peripheral behind a Wishbone B4 slave port.
// All channels share one prescaled period counter with a programmable top value.
// Duty writes land in staging registers and are copied into per-channel shadows
// only at period wrap (or continuously while disabled), so outputs never glitch.
// Build option: define PWM_POLARITY_EN to add the POLARITY register at 0x4, which
// inverts individual outputs immediately; without it 0x4 is unmapped.
module peri_pwm_multi #(
    parameter int NCHAN = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    output logic             wb_ack_o,
    input  logic [3:0]       wb_adr_i,
    input  logic [7:0]       wb_dat_i,
    output logic [7:0]       wb_dat_o,
    output logic [NCHAN-1:0] pwm_o
);

    localparam logic [3:0] ADR_CTRL     = 4'h0;
    localparam logic [3:0] ADR_PRESCALE = 4'h1;
    localparam logic [3:0] ADR_PERIOD   = 4'h2;
    localparam logic [3:0] ADR_STATUS   = 4'h3;
`ifdef PWM_POLARITY_EN
    localparam logic [3:0] ADR_POLARITY = 4'h4;
`endif

    logic             ack_r;
    logic [7:0]       dat_r;
    logic             en_r;
    logic [7:0]       prescale_r;
    logic [WIDTH-1:0] period_r;
    logic             wrap_r;
    logic [WIDTH-1:0] duty_r   [NCHAN];
    logic [WIDTH-1:0] shadow_r [NCHAN];
    logic [7:0]       pcnt_r;
    logic [WIDTH-1:0] cnt_r;
    logic [NCHAN-1:0] pwm_r;
`ifdef PWM_POLARITY_EN
    logic [NCHAN-1:0] polarity_r;
`endif

    logic             access_s;
    logic             wr_s;
    logic             tick_s;
    logic             wrap_evt_s;
    logic [7:0]       rd_data_s;
    logic [NCHAN-1:0] raw_s;

    // A bus access happens on the edge where strobe is high and no ack is pending,
    // which is also the edge that registers the ack.
    assign access_s   = wb_stb_i & ~ack_r;
    assign wr_s       = access_s & wb_we_i;
    assign tick_s     = en_r && (pcnt_r == prescale_r);
    assign wrap_evt_s = tick_s && (cnt_r >= period_r);

    // Read-data mux: staged register values, unused bits and unmapped addresses read 0
    always_comb begin
        rd_data_s = 8'h00;
        case (wb_adr_i)
            ADR_CTRL:     rd_data_s = {7'h00, en_r};
            ADR_PRESCALE: rd_data_s = prescale_r;
            ADR_PERIOD:   rd_data_s[WIDTH-1:0] = period_r;
            ADR_STATUS:   rd_data_s = {7'h00, wrap_r};
`ifdef PWM_POLARITY_EN
            ADR_POLARITY: rd_data_s[NCHAN-1:0] = polarity_r;
`endif
            default: begin
                if (wb_adr_i[3]) begin
                    for (int n = 0; n < NCHAN; n++) begin
                        rd_data_s[WIDTH-1:0] = (wb_adr_i[2:0] == 3'(n)) ? duty_r[n]
                                                                         : rd_data_s[WIDTH-1:0];
                    end
                end else begin
                    rd_data_s = 8'h00;
                end
            end
        endcase
    end

    // Bus handshake: single-cycle ack per access, read data captured on the ack edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_r <= 1'b0;
            dat_r <= 8'h00;
        end else begin
            ack_r <= access_s;
            if (access_s) begin
                dat_r <= rd_data_s;
            end else begin
                dat_r <= dat_r;
            end
        end
    end

    // Control registers and staged duty values, written on the access edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_r       <= 1'b0;
            prescale_r <= 8'h00;
            period_r   <= {WIDTH{1'b0}};
            for (int n = 0; n < NCHAN; n++) begin
                duty_r[n] <= {WIDTH{1'b0}};
            end
        end else if (wr_s) begin
            case (wb_adr_i)
                ADR_CTRL:     en_r       <= wb_dat_i[0];
                ADR_PRESCALE: prescale_r <= wb_dat_i;
                ADR_PERIOD:   period_r   <= wb_dat_i[WIDTH-1:0];
                default: begin
                    for (int n = 0; n < NCHAN; n++) begin
                        if (wb_adr_i == 4'(8 + n)) begin
                            duty_r[n] <= wb_dat_i[WIDTH-1:0];
                        end
                    end
                end
            endcase
        end
    end

`ifdef PWM_POLARITY_EN
    // Output polarity register, applied directly without shadowing
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            polarity_r <= {NCHAN{1'b0}};
        end else if (wr_s && (wb_adr_i == ADR_POLARITY)) begin
            polarity_r <= wb_dat_i[NCHAN-1:0];
        end else begin
            polarity_r <= polarity_r;
        end
    end
`endif

    // Sticky wrap flag: a wrap in the same cycle as a clear-write keeps it set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrap_r <= 1'b0;
        end else if (wrap_evt_s) begin
            wrap_r <= 1'b1;
        end else if (wr_s && (wb_adr_i == ADR_STATUS) && wb_dat_i[0]) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= wrap_r;
        end
    end

    // Prescaler and period counter; both parked at 0 while disabled so enabling starts clean
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcnt_r <= 8'h00;
            cnt_r  <= {WIDTH{1'b0}};
        end else if (!en_r) begin
            pcnt_r <= 8'h00;
            cnt_r  <= {WIDTH{1'b0}};
        end else if (tick_s) begin
            pcnt_r <= 8'h00;
            // >= so a PERIOD lowered below the running count wraps on the next tick
            cnt_r  <= wrap_evt_s ? {WIDTH{1'b0}} : cnt_r + WIDTH'(1'b1);
        end else begin
            pcnt_r <= pcnt_r + 8'h01;
            cnt_r  <= cnt_r;
        end
    end

    // Shadow duties track staging while disabled and latch it at every wrap
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int n = 0; n < NCHAN; n++) begin
                shadow_r[n] <= {WIDTH{1'b0}};
            end
        end else if (!en_r || wrap_evt_s) begin
            for (int n = 0; n < NCHAN; n++) begin
                shadow_r[n] <= duty_r[n];
            end
        end else begin
            for (int n = 0; n < NCHAN; n++) begin
                shadow_r[n] <= shadow_r[n];
            end
        end
    end

    // Raw compare: an extra zero MSB keeps the unsigned compare safe at full scale
    always_comb begin
        raw_s = {NCHAN{1'b0}};
        for (int n = 0; n < NCHAN; n++) begin
            raw_s[n] = en_r && ({1'b0, shadow_r[n]} > {1'b0, cnt_r});
        end
    end

    // Registered PWM outputs, one clock behind the counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_r <= {NCHAN{1'b0}};
        end else begin
`ifdef PWM_POLARITY_EN
            pwm_r <= raw_s ^ polarity_r;
`else
            pwm_r <= raw_s;
`endif
        end
    end

    assign wb_ack_o = ack_r;
    assign wb_dat_o = dat_r;
    assign pwm_o    = pwm_r;

endmodule

// File: tb/tb_peri_pwm_multi.sv
// Self-checking bench for peri_pwm_multi (NCHAN=4, WIDTH=8).
// Register accesses run from a vector table; read expectations go through a
// scoreboard queue and are compared when the ack appears. Multi-cycle corner
// cases (shadowing, set-wins, handshake, reset mid-period) are hand sequenced.
module tb_peri_pwm_multi;

    localparam int NCHAN = 4;
    localparam int WIDTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             wb_we_i;
    logic             wb_stb_i;
    logic             wb_ack_o;
    logic [3:0]       wb_adr_i;
    logic [7:0]       wb_dat_i;
    logic [7:0]       wb_dat_o;
    logic [NCHAN-1:0] pwm_o;

    peri_pwm_multi #(.NCHAN(NCHAN), .WIDTH(WIDTH)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wb_we_i  (wb_we_i),
        .wb_stb_i (wb_stb_i),
        .wb_ack_o (wb_ack_o),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .pwm_o    (pwm_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       we;
        logic [3:0] adr;
        logic [7:0] dat;   // write data, or expected read data
    } vec_t;

    typedef struct {
        logic [3:0] adr;
        logic [7:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    vec_t tbl[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: pass the posedge, land on the negedge, retire any read ack.
    task automatic cyc();
        logic rd;
        sb_t  e;
        rd = wb_stb_i && !wb_we_i;
        @(posedge clk_i);
        @(negedge clk_i);
        if (wb_ack_o && rd) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_ack", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("read_0x%0h", e.adr), int'(wb_dat_o), int'(e.exp));
            end
        end
    endtask

    task automatic bus_write(input logic [3:0] adr, input logic [7:0] dat);
        wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = dat;
        cyc();
        wb_stb_i = 1'b0; wb_we_i = 1'b0;
        cyc();
    endtask

    task automatic bus_read(input logic [3:0] adr, input logic [7:0] exp);
        sb_t e;
        e.adr = adr; e.exp = exp;
        sb_q.push_back(e);
        wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
        cyc();
        wb_stb_i = 1'b0;
        cyc();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
    endtask

    task automatic measure(input int ncyc, output int hi0, output int hi1,
                           output int hi2, output int hi3, output int run0);
        int cur;
        hi0 = 0; hi1 = 0; hi2 = 0; hi3 = 0; run0 = 0; cur = 0;
        for (int i = 0; i < ncyc; i++) begin
            cyc();
            hi0 += int'(pwm_o[0]);
            hi1 += int'(pwm_o[1]);
            hi2 += int'(pwm_o[2]);
            hi3 += int'(pwm_o[3]);
            cur = pwm_o[0] ? cur + 1 : 0;
            if (cur > run0) run0 = cur;
        end
    endtask

    function automatic vec_t mkv(input logic we, input logic [3:0] adr, input logic [7:0] dat);
        vec_t v;
        v.we = we; v.adr = adr; v.dat = dat;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0, h1, h2, h3, r0;
        int p1, p2, p3, p4;
        int found;
        logic [7:0] pol_exp;
        logic [3:0] pat;

`ifdef PWM_POLARITY_EN
        pol_exp = 8'h0F;
`else
        pol_exp = 8'h00;
`endif
        // Reset values first, then write/readback, unused bits and unmapped addresses.
        tbl.push_back(mkv(1'b0, 4'h0, 8'h00));
        tbl.push_back(mkv(1'b0, 4'h1, 8'h00));
        tbl.push_back(mkv(1'b0, 4'h2, 8'h00));
        tbl.push_back(mkv(1'b0, 4'h3, 8'h00));
        tbl.push_back(mkv(1'b0, 4'h4, 8'h00));
        tbl.push_back(mkv(1'b0, 4'h8, 8'h00));
        tbl.push_back(mkv(1'b0, 4'hB, 8'h00));
        tbl.push_back(mkv(1'b1, 4'h1, 8'hA5));
        tbl.push_back(mkv(1'b0, 4'h1, 8'hA5));
        tbl.push_back(mkv(1'b1, 4'h2, 8'h3C));
        tbl.push_back(mkv(1'b0, 4'h2, 8'h3C));
        tbl.push_back(mkv(1'b1, 4'h0, 8'hFE));
        tbl.push_back(mkv(1'b0, 4'h0, 8'h00));
        tbl.push_back(mkv(1'b1, 4'h8, 8'h11));
        tbl.push_back(mkv(1'b1, 4'h9, 8'h22));
        tbl.push_back(mkv(1'b1, 4'hA, 8'h33));
        tbl.push_back(mkv(1'b1, 4'hB, 8'h44));
        tbl.push_back(mkv(1'b0, 4'h8, 8'h11));
        tbl.push_back(mkv(1'b0, 4'h9, 8'h22));
        tbl.push_back(mkv(1'b0, 4'hA, 8'h33));
        tbl.push_back(mkv(1'b0, 4'hB, 8'h44));
        tbl.push_back(mkv(1'b1, 4'hC, 8'h55));
        tbl.push_back(mkv(1'b0, 4'hC, 8'h00));
        tbl.push_back(mkv(1'b1, 4'h5, 8'h77));
        tbl.push_back(mkv(1'b0, 4'h5, 8'h00));
        tbl.push_back(mkv(1'b0, 4'h7, 8'h00));
        tbl.push_back(mkv(1'b0, 4'hF, 8'h00));
        tbl.push_back(mkv(1'b1, 4'h4, 8'h0F));
        tbl.push_back(mkv(1'b0, 4'h4, pol_exp));
        tbl.push_back(mkv(1'b0, 4'h3, 8'h00));

        // Reset held two cycles with a strobed write to CTRL: nothing may respond.
        rst_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 4'h0; wb_dat_i = 8'hFF;
        cyc();
        cyc();
        check("reset_ack", int'(wb_ack_o), 0);
        check("reset_pwm", int'(pwm_o), 0);
        check("reset_dat", int'(wb_dat_o), 0);
        rst_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        cyc();

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].we) bus_write(tbl[i].adr, tbl[i].dat);
            else           bus_read(tbl[i].adr, tbl[i].dat);
        end

        // Duty resolution: PERIOD=9, no prescale; duty 3, 0, 10 (>PERIOD), 0.
        do_reset();
        bus_write(4'h2, 8'd9);
        bus_write(4'h1, 8'd0);
        bus_write(4'h8, 8'd3);
        bus_write(4'h9, 8'd0);
        bus_write(4'hA, 8'd10);
        bus_write(4'h0, 8'h01);
        for (int w = 0; w < 2; w++) begin
            measure(10, h0, h1, h2, h3, r0);
            check($sformatf("duty_ch0_w%0d", w), h0, 3);
            check($sformatf("duty_ch1_w%0d", w), h1, 0);
            check($sformatf("duty_ch2_w%0d", w), h2, 10);
            check($sformatf("duty_ch3_w%0d", w), h3, 0);
        end
        bus_read(4'h3, 8'h01);
        bus_write(4'h0, 8'h00);
        check("disabled_pwm", int'(pwm_o), 0);
        bus_write(4'h3, 8'h01);
        bus_read(4'h3, 8'h00);

        // Prescaler: PRESCALE=3, PERIOD=4, DUTY0=2 -> 20-clock period, 8 high.
        do_reset();
        bus_write(4'h1, 8'd3);
        bus_write(4'h2, 8'd4);
        bus_write(4'h8, 8'd2);
        bus_write(4'h0, 8'h01);
        measure(40, h0, h1, h2, h3, r0);
        check("presc_ch0_high", h0, 16);
        check("presc_ch0_run", r0, 8);
        check("presc_ch1_high", h1, 0);

        // Reset while channel 0 is high: outputs drop on the reset edge.
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (pwm_o[0]) found = 1;
            else cyc();
        end
        check("midreset_found_high", found, 1);
        rst_i = 1'b1;
        cyc();
        check("midreset_pwm", int'(pwm_o), 0);
        check("midreset_ack", int'(wb_ack_o), 0);
        rst_i = 1'b0;
        bus_read(4'h0, 8'h00);
        bus_read(4'h1, 8'h00);
        bus_read(4'h2, 8'h00);
        bus_read(4'h8, 8'h00);
        bus_read(4'h3, 8'h00);

        // Shadowing and same-cycle update. s counts edges after the enable edge E;
        // wraps fall on E+10, E+20, E+30. DUTY0 5->1 at E+3, 1->7 exactly at E+20.
        do_reset();
        bus_write(4'h2, 8'd9);
        bus_write(4'h8, 8'd5);
        p1 = 0; p2 = 0; p3 = 0; p4 = 0;
        wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 4'h0; wb_dat_i = 8'h01;
        for (int s = 0; s <= 40; s++) begin
            sb_t e;
            cyc();
            if (s >= 1  && s <= 10) p1 += int'(pwm_o[0]);
            if (s >= 11 && s <= 20) p2 += int'(pwm_o[0]);
            if (s >= 21 && s <= 30) p3 += int'(pwm_o[0]);
            if (s >= 31 && s <= 40) p4 += int'(pwm_o[0]);
            case (s)
                2:  begin wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 4'h8; wb_dat_i = 8'd1; end
                4:  begin
                        e.adr = 4'h8; e.exp = 8'd1; sb_q.push_back(e);
                        wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'h8;
                    end
                19: begin wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 4'h8; wb_dat_i = 8'd7; end
                default: begin wb_stb_i = 1'b0; wb_we_i = 1'b0; end
            endcase
        end
        check("shadow_period1", p1, 5);
        check("shadow_period2", p2, 1);
        check("samecycle_period3", p3, 1);
        check("samecycle_period4", p4, 7);

        // Set wins over clear: prescale 3, PERIOD 0 -> wrap on E+4, E+8 only while enabled.
        do_reset();
        bus_write(4'h1, 8'd3);
        bus_write(4'h0, 8'h01);   // E
        bus_write(4'h3, 8'h01);   // E+2, no wrap
        bus_write(4'h3, 8'h01);   // E+4, coincides with wrap
        bus_write(4'h0, 8'h00);   // E+6, disable before the next wrap
        bus_read(4'h3, 8'h01);
        bus_write(4'h3, 8'h01);
        bus_read(4'h3, 8'h00);

        // Handshake: held read strobe on PERIOD acks every other cycle.
        bus_write(4'h2, 8'h5A);
        begin
            sb_t e;
            e.adr = 4'h2; e.exp = 8'h5A;
            sb_q.push_back(e);
            sb_q.push_back(e);
        end
        wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 4'h2;
        pat[0] = wb_ack_o;
        cyc(); pat[1] = wb_ack_o;
        cyc(); pat[2] = wb_ack_o;
        cyc(); pat[3] = wb_ack_o;
        cyc();
        wb_stb_i = 1'b0;
        cyc();
        check("hs_ack0", int'(pat[0]), 0);
        check("hs_ack1", int'(pat[1]), 1);
        check("hs_ack2", int'(pat[2]), 0);
        check("hs_ack3", int'(pat[3]), 1);

`ifdef PWM_POLARITY_EN
        // Polarity: disabled channel 0 idles high; enabled it is low 3 of 10 clocks.
        do_reset();
        bus_write(4'h4, 8'h01);
        cyc();
        check("pol_idle", int'(pwm_o), 1);
        bus_write(4'h2, 8'd9);
        bus_write(4'h8, 8'd3);
        bus_write(4'h0, 8'h01);
        measure(10, h0, h1, h2, h3, r0);
        check("pol_ch0_high", h0, 7);
        check("pol_ch1_high", h1, 0);
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
